// File: rtl/recepcao_pesos_serial_pkg.sv
// circuito_pkg: shared state codes, ASCII digit bounds and frame slot offsets
package circuito_pkg;
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    START = 4'd1,
    DATA  = 4'd2,
    STOP  = 4'd3,
    CHECK = 4'd4
  } estado_t;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;
  localparam int PESO_MAX   = 0;
  localparam int PESO_MIN   = 2;
  localparam int PESO_ATUAL = 4;
  function automatic logic eh_digito(input logic [7:0] b);
    return b >= ASCII_0 && b <= ASCII_9;
  endfunction
endpackage

// File: rtl/recepcao_pesos_serial_if.sv
// recepcao_pesos_serial_if: serial line in, frame/status out
interface recepcao_pesos_serial_if #(parameter int NUM_BYTES = 6);
  logic                     entrada_serial;
  logic [8*NUM_BYTES-1:0]   valor_reg;
  logic                     fim_recepcao;
  logic                     erro_recepcao;
  logic [2:0]               db_bytes;
  logic [3:0]               db_estado;
  modport master(output entrada_serial, input valor_reg, fim_recepcao, erro_recepcao, db_bytes, db_estado);
  modport slave(input entrada_serial, output valor_reg, fim_recepcao, erro_recepcao, db_bytes, db_estado);
endinterface

// File: rtl/recepcao_pesos_serial_rx.sv
// uart_rx_byte: synchronized 8N1 byte receiver with falling-edge start detect
module uart_rx_byte
  import circuito_pkg::*;
#(
  parameter int BIT_TICKS = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [7:0] dado,
  output logic       byte_pronto,
  output logic       erro_stop,
  output logic [3:0] estado
);
  localparam int TW = $clog2(BIT_TICKS);
  logic s1, s2, s3;
  estado_t st, nx;
  logic [TW-1:0] tick;
  logic [2:0] nbits;
  logic stop_bit;
  logic meio, fim_bit;
  assign meio        = tick == TW'(BIT_TICKS / 2 - 1);
  assign fim_bit     = tick == TW'(BIT_TICKS - 1);
  assign byte_pronto = st == CHECK;
  assign erro_stop   = ~stop_bit;
  assign estado      = st;
  // two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clock or posedge reset)
    if (reset) {s1, s2, s3} <= 3'b111;
    else {s1, s2, s3} <= {entrada_serial, s1, s2};
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) st <= IDLE;
    else st <= nx;
  // next state: a start needs a fresh falling edge, so a stuck-low line cannot retrigger
  always_comb begin
    nx = st;
    case (st)
      IDLE:    nx = (!s2 && s3) ? START : IDLE;
      START:   if (meio) nx = s2 ? IDLE : DATA;
      DATA:    if (fim_bit && nbits == 3'd7) nx = STOP;
      STOP:    if (fim_bit) nx = CHECK;
      CHECK:   nx = IDLE;
      default: nx = IDLE;
    endcase
  end
  // bit timing, LSB-first shift and stop-bit capture
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      tick     <= '0;
      nbits    <= '0;
      dado     <= '0;
      stop_bit <= 1'b0;
    end else begin
      tick  <= (st == IDLE || st == CHECK || (st == START && meio) || fim_bit) ? '0 : tick + 1'b1;
      nbits <= (st == IDLE) ? 3'd0 : (st == DATA && fim_bit) ? nbits + 3'd1 : nbits;
      if (st == DATA && fim_bit) dado <= {s2, dado[7:1]};
      if (st == STOP && fim_bit) stop_bit <= s2;
    end
endmodule

// File: rtl/recepcao_pesos_serial.sv
// recepcao_pesos_serial: validates ASCII digit bytes and publishes complete weight frames
module recepcao_pesos_serial
  import circuito_pkg::*;
#(
  parameter int BIT_TICKS    = 434,
  parameter int NUM_BYTES    = 6,
  parameter int TIMEOUT_BITS = 20
) (
  input logic clock,
  input logic reset,
  recepcao_pesos_serial_if.slave bus
);
  localparam int W      = 8 * NUM_BYTES;
  localparam int LIMITE = TIMEOUT_BITS * BIT_TICKS;
  localparam int CW     = $clog2(LIMITE + 1);
  logic [7:0] dado;
  logic pronto, erro_stop, valido, ultimo;
  logic [3:0] estado;
  logic [W-1:0] sombra, sombra_nx;
  logic [CW-1:0] ociosos;
  uart_rx_byte #(.BIT_TICKS(BIT_TICKS)) u_rx (
    .clock(clock),
    .reset(reset),
    .entrada_serial(bus.entrada_serial),
    .dado(dado),
    .byte_pronto(pronto),
    .erro_stop(erro_stop),
    .estado(estado)
  );
  assign bus.db_estado = estado;
  assign valido = !erro_stop && eh_digito(dado);
  assign ultimo = bus.db_bytes == 3'(NUM_BYTES - 1);
  // shadow with the incoming byte dropped into its slot; first byte lands in the top byte
  always_comb begin
    sombra_nx = sombra;
    sombra_nx[(NUM_BYTES - 1 - int'(bus.db_bytes)) * 8 +: 8] = dado;
  end
  // slot counter, shadow, atomic frame publish, sticky error and inter-byte timeout
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sombra            <= {NUM_BYTES{ASCII_0}};
      bus.valor_reg     <= {NUM_BYTES{ASCII_0}};
      bus.fim_recepcao  <= 1'b0;
      bus.erro_recepcao <= 1'b0;
      bus.db_bytes      <= '0;
      ociosos           <= '0;
    end else begin
      bus.fim_recepcao <= pronto && valido && ultimo;
      ociosos <= (estado == 4'(IDLE) && bus.db_bytes != 3'd0 && ociosos != CW'(LIMITE)) ? ociosos + 1'b1 : '0;
      if (pronto) begin
        if (!valido) begin
          bus.erro_recepcao <= 1'b1;
          bus.db_bytes      <= '0;
        end else if (ultimo) begin
          bus.valor_reg     <= sombra_nx;
          bus.erro_recepcao <= 1'b0;
          bus.db_bytes      <= '0;
        end else begin
          sombra       <= sombra_nx;
          bus.db_bytes <= bus.db_bytes + 3'd1;
        end
      end else if (ociosos == CW'(LIMITE)) bus.db_bytes <= '0;
    end
endmodule

// File: tb/tb_recepcao_pesos_serial.sv
// tb_recepcao_pesos_serial: directed frames, errors, glitch, timeout and reset abort
module tb_recepcao_pesos_serial;
  localparam int BT = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  int pulsos = 0;
  int p0;
  logic [7:0] b3;
  recepcao_pesos_serial_if bus();
  recepcao_pesos_serial #(.BIT_TICKS(BT), .NUM_BYTES(6), .TIMEOUT_BITS(20)) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.fim_recepcao) pulsos++;
  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic line(input logic v, input int n);
    bus.entrada_serial = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    line(1'b0, BT);
    for (int i = 0; i < 8; i++) line(b[i], BT);
    line(stop, BT);
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask
  task automatic idle(input int bits);
    line(1'b1, bits * BT);
  endtask
  initial begin
    bus.entrada_serial = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valor", bus.valor_reg, 48'h303030303030);
    check("rst_fim", bus.fim_recepcao, 0);
    check("rst_erro", bus.erro_recepcao, 0);
    check("rst_bytes", bus.db_bytes, 0);
    check("rst_estado", bus.db_estado, 0);
    rst = 1'b0;
    idle(2);
    p0 = pulsos;
    send_str("120509");
    idle(2);
    check("t1_pulsos", pulsos, p0 + 1);
    check("t1_valor", bus.valor_reg, 48'h313230353039);
    check("t1_erro", bus.erro_recepcao, 0);
    check("t1_bytes", bus.db_bytes, 0);
    p0 = pulsos;
    send_str("12");
    send_byte(8'h41);
    idle(1);
    check("t2_erro_set", bus.erro_recepcao, 1);
    check("t2_bytes_clr", bus.db_bytes, 0);
    check("t2_sem_pulso", pulsos, p0);
    send_str("050912");
    idle(2);
    check("t2_pulsos", pulsos, p0 + 1);
    check("t2_valor", bus.valor_reg, 48'h303530393132);
    check("t2_erro_clr", bus.erro_recepcao, 0);
    line(1'b0, 2);
    idle(2);
    check("t3_glitch_estado", bus.db_estado, 0);
    check("t3_glitch_erro", bus.erro_recepcao, 0);
    check("t3_glitch_bytes", bus.db_bytes, 0);
    p0 = pulsos;
    send_str("999999");
    idle(2);
    check("t3_pulsos", pulsos, p0 + 1);
    check("t3_valor", bus.valor_reg, 48'h393939393939);
    p0 = pulsos;
    send_str("12");
    idle(15);
    check("t4_antes_timeout", bus.db_bytes, 2);
    idle(10);
    check("t4_timeout_bytes", bus.db_bytes, 0);
    check("t4_timeout_erro", bus.erro_recepcao, 0);
    send_str("3407");
    idle(1);
    check("t4_quatro_bytes", bus.db_bytes, 4);
    check("t4_sem_pulso", pulsos, p0);
    send_str("08");
    idle(2);
    check("t4_pulsos", pulsos, p0 + 1);
    check("t4_valor", bus.valor_reg, 48'h333430373038);
    p0 = pulsos;
    send_byte(8'h35, 1'b0);
    idle(2);
    check("t5_erro", bus.erro_recepcao, 1);
    check("t5_bytes", bus.db_bytes, 0);
    check("t5_valor", bus.valor_reg, 48'h333430373038);
    check("t5_sem_pulso", pulsos, p0);
    send_str("12");
    b3 = 8'h30;
    line(1'b0, BT);
    for (int i = 0; i < 4; i++) line(b3[i], BT);
    bus.entrada_serial = b3[4];
    #3 rst = 1'b1;
    #1;
    check("t6_rst_valor", bus.valor_reg, 48'h303030303030);
    check("t6_rst_bytes", bus.db_bytes, 0);
    check("t6_rst_erro", bus.erro_recepcao, 0);
    check("t6_rst_estado", bus.db_estado, 0);
    check("t6_rst_fim", bus.fim_recepcao, 0);
    @(negedge clk);
    bus.entrada_serial = 1'b1;
    rst = 1'b0;
    idle(3);
    check("t6_sem_pulso", pulsos, p0);
    send_str("000001");
    idle(2);
    check("t6_pulsos", pulsos, p0 + 1);
    check("t6_valor", bus.valor_reg, 48'h303030303031);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
